// File: rtl/regfile_multiport_pkg.sv
// Shared defaults for the multiport register file and its pending-bit scoreboard.
package regfile_multiport_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_NUM_RD   = 2;
  localparam int CLOCK_PERIOD     = 10;

  // Width needed to hold a population count of n bits (0..n inclusive).
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set by a lock (producer issued),
// cleared by a write-back, with a registered population count.
module regfile_scoreboard
  import regfile_multiport_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = count_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       lock_en,
  input  logic [AW-1:0]              lock_addr,
  input  logic                       clr_en,
  input  logic [AW-1:0]              clr_addr,
  input  logic [NUM_RD-1:0][AW-1:0]  rd_addr,
  output logic [NUM_RD-1:0]          rd_pending,
  output logic [CW-1:0]              pending_count
);

  logic [NUM_REGS-1:0] pending_reg, pending_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                lock_ok;
  logic                inc;
  logic                dec;

  // Next pending vector and count delta; a lock beats a clear on the same
  // register because the newer producer still owes a result.
  always_comb begin
    lock_ok      = lock_en && !((ZERO_REG != 0) && (lock_addr == '0));
    inc          = lock_ok && !pending_reg[lock_addr];
    dec          = clr_en && pending_reg[clr_addr] &&
                   !(lock_ok && (lock_addr == clr_addr));
    pending_next = pending_reg;
    if (clr_en)  pending_next[clr_addr]  = 1'b0;
    if (lock_ok) pending_next[lock_addr] = 1'b1;
    count_next   = count_reg + CW'(inc) - CW'(dec);
  end

  // Pending bits and count update together so the count always equals the population.
  always_ff @(posedge clk) begin
    if (srst) begin
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      assign rd_pending[gi] = pending_reg[rd_addr[gi]];
    end
  endgenerate

  assign pending_count = count_reg;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with optional hardwired x0,
// optional write-to-read forwarding and a pending-producer scoreboard.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = count_w(NUM_REGS)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          REG_W_En,
  input  logic [AW-1:0]                 REG_W_Addr,
  input  logic [DATA_W-1:0]             REG_W_Data,
  input  logic [NUM_RD-1:0][AW-1:0]     REG_R_Addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] REG_R_Data,
  input  logic                          REG_Lock_En,
  input  logic [AW-1:0]                 REG_Lock_Addr,
  output logic [NUM_RD-1:0]             REG_R_Pending,
  output logic [CW-1:0]                 REG_Pending_Count
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic [NUM_RD-1:0] sb_pending;
  logic              w_live;

  // A write to a hardwired x0 is dropped entirely, so it can neither store nor forward.
  assign w_live = REG_W_En && !((ZERO_REG != 0) && (REG_W_Addr == '0));

  // Register storage: cleared by reset, otherwise a single write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (w_live) begin
      regs_reg[REG_W_Addr] <= REG_W_Data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (CLK),
    .srst          (RST),
    .lock_en       (REG_Lock_En),
    .lock_addr     (REG_Lock_Addr),
    .clr_en        (REG_W_En),
    .clr_addr      (REG_W_Addr),
    .rd_addr       (REG_R_Addr),
    .rd_pending    (sb_pending),
    .pending_count (REG_Pending_Count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic              zero_hit;
      logic              byp_hit;
      logic [DATA_W-1:0] rd_val;

      // Read mux: hardwired zero first, then forwarded write data, then storage.
      always_comb begin
        zero_hit = (ZERO_REG != 0) && (REG_R_Addr[gi] == '0);
        byp_hit  = (BYPASS != 0) && w_live && (REG_W_Addr == REG_R_Addr[gi]);
        if (zero_hit)     rd_val = '0;
        else if (byp_hit) rd_val = REG_W_Data;
        else              rd_val = regs_reg[REG_R_Addr[gi]];
      end

      assign REG_R_Data[gi]    = rd_val;
      // A forwarded result is by definition no longer pending.
      assign REG_R_Pending[gi] = sb_pending[gi] && !byp_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: dut_a uses defaults (x0 hardwired, bypass on, 2 read ports),
// dut_b uses x0 ordinary, bypass off, 4 read ports; both share write/lock/reset.
module tb_regfile_multiport;
  import regfile_multiport_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  w_en = 1'b0;
  logic [4:0]            w_addr = '0;
  logic [31:0]           w_data = '0;
  logic                  lock_en = 1'b0;
  logic [4:0]            lock_addr = '0;

  logic [1:0][4:0]       ra_a;
  logic [1:0][31:0]      rd_a;
  logic [1:0]            rp_a;
  logic [5:0]            cnt_a;

  logic [3:0][4:0]       ra_b;
  logic [3:0][31:0]      rd_b;
  logic [3:0]            rp_b;
  logic [5:0]            cnt_b;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_a [32];
  logic [31:0] model_b [32];
  logic [31:0] pat;

  always #(CLOCK_PERIOD / 2) clk = ~clk;

  regfile_multiport #(.NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(clk), .RST(rst), .REG_W_En(w_en), .REG_W_Addr(w_addr), .REG_W_Data(w_data),
    .REG_R_Addr(ra_a), .REG_R_Data(rd_a), .REG_Lock_En(lock_en), .REG_Lock_Addr(lock_addr),
    .REG_R_Pending(rp_a), .REG_Pending_Count(cnt_a)
  );

  regfile_multiport #(.NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(clk), .RST(rst), .REG_W_En(w_en), .REG_W_Addr(w_addr), .REG_W_Data(w_data),
    .REG_R_Addr(ra_b), .REG_R_Data(rd_b), .REG_Lock_En(lock_en), .REG_Lock_Addr(lock_addr),
    .REG_R_Pending(rp_b), .REG_Pending_Count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra_a[0] = 5'(i);
      ra_a[1] = 5'(i);
      for (int p = 0; p < 4; p++) ra_b[p] = 5'(i);
      #1;
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s a d x%0d p%0d", tag, i, p), rd_a[p], 32'h0);
        check($sformatf("%s a pend x%0d p%0d", tag, i, p), 32'(rp_a[p]), 32'h0);
      end
      for (int p = 0; p < 4; p++) begin
        check($sformatf("%s b d x%0d p%0d", tag, i, p), rd_b[p], 32'h0);
        check($sformatf("%s b pend x%0d p%0d", tag, i, p), 32'(rp_b[p]), 32'h0);
      end
    end
  endtask

  initial begin
    ra_a = '0;
    ra_b = '0;

    // Reset, then every address on every port reads zero and not pending.
    step();
    step();
    rst = 1'b0;
    check("rst cnt_a", 32'(cnt_a), 32'd0);
    check("rst cnt_b", 32'(cnt_b), 32'd0);
    check_all_zero("rst");

    // Write to x0: discarded with hardwired x0, stored otherwise.
    w_en = 1'b1; w_addr = 5'd0; w_data = 32'hDEADBEEF;
    ra_a[0] = 5'd0; ra_b[0] = 5'd0;
    #1;
    check("x0 byp a", rd_a[0], 32'h0);
    check("x0 same-cyc b", rd_b[0], 32'h0);
    step();
    w_en = 1'b0;
    #1;
    check("x0 read a", rd_a[0], 32'h0);
    check("x0 read b", rd_b[0], 32'hDEADBEEF);

    // Forwarding on x31 through port 1.
    w_en = 1'b1; w_addr = 5'd31; w_data = 32'h2A2A2A2A;
    ra_a[1] = 5'd31; ra_b[1] = 5'd31;
    #1;
    check("x31 byp a", rd_a[1], 32'h2A2A2A2A);
    check("x31 nobyp b", rd_b[1], 32'h0);
    step();
    w_en = 1'b0;
    #1;
    check("x31 next a", rd_a[1], 32'h2A2A2A2A);
    check("x31 next b", rd_b[1], 32'h2A2A2A2A);

    // Lock x5, x6, x5 -> 1, 2, 2.
    lock_en = 1'b1; lock_addr = 5'd5;
    step();
    check("lock5 cnt_a", 32'(cnt_a), 32'd1);
    check("lock5 cnt_b", 32'(cnt_b), 32'd1);
    lock_addr = 5'd6;
    step();
    check("lock6 cnt_a", 32'(cnt_a), 32'd2);
    check("lock6 cnt_b", 32'(cnt_b), 32'd2);
    lock_addr = 5'd5;
    step();
    lock_en = 1'b0;
    check("relock5 cnt_a", 32'(cnt_a), 32'd2);
    check("relock5 cnt_b", 32'(cnt_b), 32'd2);
    ra_a[0] = 5'd5; ra_a[1] = 5'd6; ra_b[0] = 5'd5;
    #1;
    check("pend5 a", 32'(rp_a[0]), 32'd1);
    check("pend6 a", 32'(rp_a[1]), 32'd1);
    check("pend5 b", 32'(rp_b[0]), 32'd1);

    // Write-back of x5 clears its pending bit.
    w_en = 1'b1; w_addr = 5'd5; w_data = 32'h00000055;
    #1;
    check("wb5 byp pend a", 32'(rp_a[0]), 32'd0);
    check("wb5 nobyp pend b", 32'(rp_b[0]), 32'd1);
    step();
    w_en = 1'b0;
    #1;
    check("wb5 cnt_a", 32'(cnt_a), 32'd1);
    check("wb5 cnt_b", 32'(cnt_b), 32'd1);
    check("wb5 pend a", 32'(rp_a[0]), 32'd0);
    check("wb6 still pend a", 32'(rp_a[1]), 32'd1);
    check("wb5 data a", rd_a[0], 32'h00000055);

    // Lock and write x7 together: data lands, pending stays set.
    lock_en = 1'b1; lock_addr = 5'd7;
    w_en = 1'b1; w_addr = 5'd7; w_data = 32'h77777777;
    step();
    lock_en = 1'b0; w_en = 1'b0;
    ra_a[0] = 5'd7; ra_a[1] = 5'd7; ra_b[0] = 5'd7; ra_b[3] = 5'd7;
    #1;
    check("lw7 d a p0", rd_a[0], 32'h77777777);
    check("lw7 d a p1", rd_a[1], 32'h77777777);
    check("lw7 pend a p0", 32'(rp_a[0]), 32'd1);
    check("lw7 pend a p1", 32'(rp_a[1]), 32'd1);
    check("lw7 d b p3", rd_b[3], 32'h77777777);
    check("lw7 cnt_a", 32'(cnt_a), 32'd2);
    check("lw7 cnt_b", 32'(cnt_b), 32'd2);

    // Lock x0: ignored with hardwired x0, counted otherwise.
    lock_en = 1'b1; lock_addr = 5'd0;
    step();
    lock_en = 1'b0;
    ra_a[0] = 5'd0; ra_b[0] = 5'd0;
    #1;
    check("lock0 cnt_a", 32'(cnt_a), 32'd2);
    check("lock0 cnt_b", 32'(cnt_b), 32'd3);
    check("lock0 pend a", 32'(rp_a[0]), 32'd0);
    check("lock0 pend b", 32'(rp_b[0]), 32'd1);

    // Fill every register; each write also clears any pending bit.
    for (int i = 0; i < 32; i++) begin
      pat = 32'h9E3779B9 * 32'(i + 1);
      w_en = 1'b1; w_addr = 5'(i); w_data = pat;
      model_a[i] = (i == 0) ? 32'h0 : pat;
      model_b[i] = pat;
      step();
    end
    w_en = 1'b0;
    check("fill cnt_a", 32'(cnt_a), 32'd0);
    check("fill cnt_b", 32'(cnt_b), 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra_a[0] = 5'(i);
      ra_a[1] = 5'((i + 1) % 32);
      for (int p = 0; p < 4; p++) ra_b[p] = 5'((i + p) % 32);
      #1;
      check($sformatf("pair a x%0d", i), rd_a[0], model_a[i]);
      check($sformatf("pair a x%0d", (i + 1) % 32), rd_a[1], model_a[(i + 1) % 32]);
      for (int p = 0; p < 4; p++)
        check($sformatf("quad b x%0d", (i + p) % 32), rd_b[p], model_b[(i + p) % 32]);
    end

    // Reset mid-sequence; outputs hold pre-edge state during the reset cycle.
    lock_en = 1'b1; lock_addr = 5'd9;
    step();
    rst = 1'b1;
    w_en = 1'b1; w_addr = 5'd3; w_data = 32'hFFFFFFFF;
    lock_addr = 5'd10;
    ra_a[0] = 5'd3; ra_a[1] = 5'd9; ra_b[0] = 5'd3; ra_b[1] = 5'd9;
    #1;
    check("rstcyc byp a", rd_a[0], 32'hFFFFFFFF);
    check("rstcyc old b", rd_b[0], model_b[3]);
    check("rstcyc pend a", 32'(rp_a[1]), 32'd1);
    check("rstcyc cnt_a", 32'(cnt_a), 32'd1);
    step();
    rst = 1'b0; w_en = 1'b0; lock_en = 1'b0;
    #1;
    check("postrst x3 a", rd_a[0], 32'h0);
    check("postrst x3 b", rd_b[0], 32'h0);
    check("postrst pend9 a", 32'(rp_a[1]), 32'd0);
    check("postrst pend9 b", 32'(rp_b[1]), 32'd0);
    check("postrst cnt_a", 32'(cnt_a), 32'd0);
    check("postrst cnt_b", 32'(cnt_b), 32'd0);
    check_all_zero("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count (power of two, >=2); AW = $clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1, ordinary register when 0.
REQ-005 Parameter BYPASS, default 1, write-to-read same-cycle forwarding when 1.
REQ-006 CLK  in  1  clock; all state updates on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 REG_W_En  in  1  write enable.
REQ-009 REG_W_Addr  in  AW  write address.
REQ-010 REG_W_Data  in  DATA_W  write data.
REQ-011 REG_R_Addr  in  NUM_RD x AW  read addresses, one per port.
REQ-012 REG_R_Data  out  NUM_RD x DATA_W  read data, one per port.
REQ-013 REG_Lock_En  in  1  mark a register pending (producer issued).
REQ-014 REG_Lock_Addr  in  AW  register to mark pending.
REQ-015 REG_R_Pending  out  NUM_RD  pending flag for each read port's address.
REQ-016 REG_Pending_Count  out  $clog2(NUM_REGS+1)  number of registers currently pending.

Function
REQ-017 Reads SHALL be combinational: REG_R_Data[p] = stored value of REG_R_Addr[p], zero latency.
REQ-018 Write SHALL commit REG_W_Data to REG_W_Addr on the rising edge when REG_W_En=1 and RST=0.
REQ-019 ZERO_REG=1: writes to address 0 SHALL be discarded; reads of 0 SHALL return 0 on every port, including under bypass.
REQ-020 BYPASS=1: when REG_W_En=1 and REG_W_Addr==REG_R_Addr[p] (and not hardwired 0), REG_R_Data[p] SHALL equal REG_W_Data in that same cycle; BYPASS=0: old stored value until the edge.
REQ-021 Each register SHALL carry a pending bit; REG_Lock_En=1 sets bit REG_Lock_Addr at the edge.
REQ-022 REG_W_En=1 SHALL clear pending bit REG_W_Addr at the edge.
REQ-023 Lock and write to the same address in the same cycle: pending SHALL end set (new producer wins).
REQ-024 ZERO_REG=1: register 0 SHALL never become pending.
REQ-025 REG_R_Pending[p] SHALL reflect the stored bit; BYPASS=1 and a same-cycle write to that address SHALL force it 0.
REQ-026 Lock to an already-pending register SHALL leave it set and not change the count.
REQ-027 REG_Pending_Count SHALL be registered, equal the population of pending bits after each edge; net change per cycle in {-1,0,+1}; never wraps (max NUM_REGS, or NUM_REGS-1 with ZERO_REG=1).
REQ-028 Multiple read ports addressing the same register SHALL return identical data and pending flags.

Reset
REQ-029 RST=1 at an edge SHALL clear all registers to 0, all pending bits to 0, REG_Pending_Count to 0; writes and locks that cycle are ignored.
REQ-030 During reset cycle, outputs SHALL follow stored pre-edge state combinationally (no asynchronous clearing); bypass stays active.

Structure
REQ-031 Default widths, NUM_REGS default and CLOCK_PERIOD SHALL live in package definitions; module parameters default from it.
REQ-032 Pending-bit tracking and counter SHALL be a sub-module regfile_scoreboard (lock/clear ports, NUM_RD pending lookups, count output).

Verification
REQ-033 Reset then read all addresses on all ports -> every REG_R_Data = 0, REG_R_Pending = 0, count = 0.
REQ-034 Write 0xDEADBEEF to x0 (ZERO_REG=1) then read x0 -> 0x00000000; same with ZERO_REG=0 -> 0xDEADBEEF.
REQ-035 BYPASS=1, write 0x2A2A2A2A to x31 while port 1 reads x31 -> 0x2A2A2A2A same cycle; BYPASS=0 -> 0 same cycle, 0x2A2A2A2A next.
REQ-036 Lock x5, x6, x5 on three cycles -> count 1,2,2; write x5 -> count 1, REG_R_Pending for x5 = 0.
REQ-037 Same-cycle lock and write x7 -> x7 data updated, pending 1, count +1; lock x0 -> count unchanged.
REQ-038 Random writes to all registers, then read pairs (i,i+1) on NUM_RD=2 and all ports on NUM_RD=4 -> match reference model; assert RST mid-sequence -> all zero next cycle.
